// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target endpoint.
// Optional clock stretching is selected with I2C_TARGET_STRETCH_EN.
package i2c_pkg;

    localparam int   I2C_BYTE_W = 8;
    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Pad synchronizer for SCL/SDA with edge and START/STOP detection.
// Chains reset to 1 so a reset looks like an idle bus.
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_ff[SYNC_STAGES-1];
    assign sda_s = sda_ff[SYNC_STAGES-1];

    // Shift pads through the synchronizer and keep one delayed copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_in};
            sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_in};
            scl_d  <= scl_s;
            sda_d  <= sda_s;
        end
    end

    // SDA moving while SCL stays high is a bus condition, not data.
    always_comb begin
        sda      = sda_s;
        scl_rise = scl_s & ~scl_d;
        scl_fall = ~scl_s & scl_d;
        start    = scl_s & scl_d & sda_d & ~sda_s;
        stop     = scl_s & scl_d & ~sda_d & sda_s;
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, byte receive and byte transmit.
// Define I2C_TARGET_STRETCH_EN to stretch SCL when no read byte is ready.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  i2c_reset_n,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic                  scl_oe,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_req,
    output logic                  tx_underrun,
    output logic                  busy,
    output logic                  addressed,
    output logic                  rw
);

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (i2c_reset_n),
        .scl_in  (scl_in),
        .sda_in  (sda_in),
        .sda     (sda),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start),
        .stop    (stop)
    );

    i2c_state_e            state_q, state_n;
    logic [2:0]            cnt_q, cnt_n;
    logic [I2C_BYTE_W-1:0] sh_q, sh_n, sh_in;
    logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_n;
    logic                  sda_oe_q, sda_oe_n;
    logic                  scl_oe_q, scl_oe_n;
    logic                  rw_q, rw_n;
    logic                  addr_q, addr_n;
    logic                  busy_q, busy_n;
    logic                  rx_valid_q, rx_valid_n;
    logic                  tx_req_q, tx_req_n;
    logic                  und_q, und_n;
    logic                  ack_drv_q, ack_drv_n;
    logic                  pend_q, pend_n;
    logic                  load;

    // State and datapath registers.
    always_ff @(posedge clk or negedge i2c_reset_n) begin
        if (!i2c_reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd7;
            sh_q       <= '0;
            rx_data_q  <= '0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            und_q      <= 1'b0;
            ack_drv_q  <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            sh_q       <= sh_n;
            rx_data_q  <= rx_data_n;
            sda_oe_q   <= sda_oe_n;
            scl_oe_q   <= scl_oe_n;
            rw_q       <= rw_n;
            addr_q     <= addr_n;
            busy_q     <= busy_n;
            rx_valid_q <= rx_valid_n;
            tx_req_q   <= tx_req_n;
            und_q      <= und_n;
            ack_drv_q  <= ack_drv_n;
            pend_q     <= pend_n;
        end
    end

    // Next-state and output logic; bus conditions override everything.
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        sh_n       = sh_q;
        rx_data_n  = rx_data_q;
        sda_oe_n   = sda_oe_q;
        scl_oe_n   = scl_oe_q;
        rw_n       = rw_q;
        addr_n     = addr_q;
        busy_n     = busy_q;
        rx_valid_n = 1'b0;
        tx_req_n   = 1'b0;
        und_n      = 1'b0;
        ack_drv_n  = ack_drv_q;
        pend_n     = pend_q;
        load       = 1'b0;
        sh_in      = {sh_q[I2C_BYTE_W-2:0], sda};

        unique case (state_q)
            IDLE: begin
            end
            ADDR: begin
                if (scl_rise) begin
                    sh_n = sh_in;
                    if (cnt_q == 3'd0) begin
                        if (sh_in[7:1] == TARGET_ADDR) begin
                            state_n   = ADDR_ACK;
                            rw_n      = sh_in[0];
                            addr_n    = 1'b1;
                            ack_drv_n = 1'b0;
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end else begin
                        cnt_n = cnt_q - 3'd1;
                    end
                end
            end
            ADDR_ACK: begin
                if (scl_fall) begin
                    if (!ack_drv_q) begin
                        sda_oe_n  = 1'b1;
                        ack_drv_n = 1'b1;
                        tx_req_n  = rw_q;
                    end else begin
                        sda_oe_n  = 1'b0;
                        ack_drv_n = 1'b0;
                        cnt_n     = 3'd7;
                        if (rw_q) begin
                            load = 1'b1;
                        end else begin
                            state_n = RX_BYTE;
                        end
                    end
                end
            end
            RX_BYTE: begin
                if (scl_rise) begin
                    sh_n = sh_in;
                    if (cnt_q == 3'd0) begin
                        rx_data_n  = sh_in;
                        rx_valid_n = 1'b1;
                        ack_drv_n  = 1'b0;
                        state_n    = RX_ACK;
                    end else begin
                        cnt_n = cnt_q - 3'd1;
                    end
                end
            end
            RX_ACK: begin
                if (scl_fall) begin
                    if (!ack_drv_q) begin
                        sda_oe_n  = 1'b1;
                        ack_drv_n = 1'b1;
                    end else begin
                        sda_oe_n  = 1'b0;
                        ack_drv_n = 1'b0;
                        cnt_n     = 3'd7;
                        state_n   = RX_BYTE;
                    end
                end
            end
            TX_BYTE: begin
                if (pend_q) begin
                    if (scl_fall || scl_oe_q) begin
                        load = 1'b1;
                    end
                end else if (scl_fall) begin
                    if (cnt_q == 3'd0) begin
                        sda_oe_n = 1'b0;
                        state_n  = TX_ACK;
                    end else begin
                        cnt_n    = cnt_q - 3'd1;
                        sh_n     = {sh_q[I2C_BYTE_W-2:0], 1'b1};
                        sda_oe_n = ~sh_q[I2C_BYTE_W-2];
                    end
                end
            end
            TX_ACK: begin
                if (scl_rise) begin
                    if (sda == I2C_ACK) begin
                        tx_req_n = 1'b1;
                        pend_n   = 1'b1;
                        state_n  = TX_BYTE;
                    end else begin
                        state_n = WAIT_STOP;
                    end
                end
            end
            WAIT_STOP: begin
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Load the read shifter at the fall that ends an ACK.
        if (load) begin
            state_n = TX_BYTE;
            cnt_n   = 3'd7;
            if (tx_valid) begin
                sh_n     = tx_data;
                sda_oe_n = ~tx_data[I2C_BYTE_W-1];
                pend_n   = 1'b0;
                scl_oe_n = 1'b0;
            end else begin
`ifdef I2C_TARGET_STRETCH_EN
                sda_oe_n = 1'b0;
                pend_n   = 1'b1;
                scl_oe_n = 1'b1;
`else
                sh_n     = 8'hFF;
                sda_oe_n = 1'b0;
                pend_n   = 1'b0;
                und_n    = 1'b1;
`endif
            end
        end

        if (start) begin
            state_n   = ADDR;
            cnt_n     = 3'd7;
            busy_n    = 1'b1;
            addr_n    = 1'b0;
            sda_oe_n  = 1'b0;
            scl_oe_n  = 1'b0;
            ack_drv_n = 1'b0;
            pend_n    = 1'b0;
            tx_req_n  = 1'b0;
            und_n     = 1'b0;
        end else if (stop) begin
            state_n   = IDLE;
            busy_n    = 1'b0;
            addr_n    = 1'b0;
            sda_oe_n  = 1'b0;
            scl_oe_n  = 1'b0;
            ack_drv_n = 1'b0;
            pend_n    = 1'b0;
            tx_req_n  = 1'b0;
            und_n     = 1'b0;
        end
    end

    // Registered outputs.
    always_comb begin
        sda_oe      = sda_oe_q;
        scl_oe      = scl_oe_q;
        rx_data     = rx_data_q;
        rx_valid    = rx_valid_q;
        tx_req      = tx_req_q;
        tx_underrun = und_q;
        busy        = busy_q;
        addressed   = addr_q;
        rw          = rw_q;
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bus master model plus client model.
// Honours I2C_TARGET_STRETCH_EN when the design is built with it.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q     = 5;
    localparam int LIMIT = 2000;

    logic       clk = 1'b0;
    logic       i2c_reset_n;
    logic       m_scl;
    logic       m_sda;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       scl_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid;
    logic       tx_req;
    logic       tx_underrun;
    logic       busy;
    logic       addressed;
    logic       rw;

    int n_cmp = 0;
    int n_bad = 0;

    int         rx_cnt = 0;
    logic [7:0] rx_log [0:15];
    logic [7:0] tx_q [0:7];
    int         tx_idx = 0;
    int         req_cnt = 0;
    int         und_cnt = 0;
    int         oe_seen = 0;
    int         oe_rise = 0;
    int         str_clk = 0;
    logic       prev_oe = 1'b0;

    assign scl_in = m_scl & ~scl_oe;
    assign sda_in = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target dut (
        .clk        (clk),
        .i2c_reset_n(i2c_reset_n),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .sda_oe     (sda_oe),
        .scl_oe     (scl_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_req     (tx_req),
        .tx_underrun(tx_underrun),
        .busy       (busy),
        .addressed  (addressed),
        .rw         (rw)
    );

    // Client and event monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt[3:0]] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (tx_req) begin
            tx_data <= tx_q[tx_idx[2:0]];
            tx_idx  <= tx_idx + 1;
            req_cnt <= req_cnt + 1;
        end
        if (tx_underrun) und_cnt <= und_cnt + 1;
        if (sda_oe) oe_seen <= oe_seen + 1;
        if (sda_oe && !prev_oe) oe_rise <= oe_rise + 1;
        if (scl_oe) str_clk <= str_clk + 1;
        prev_oe <= sda_oe;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic qtr();
        repeat (Q) @(negedge clk);
    endtask

    task automatic scl_high();
        int n;
        n = 0;
        m_scl = 1'b1;
        while (scl_in !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("scl_wait_timeout", 32'(n >= LIMIT), 32'd0);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        m_sda = b;
        qtr();
        scl_high();
        qtr();
        s = sda_in;
        qtr();
        m_scl = 1'b0;
        qtr();
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        qtr();
        scl_high();
        qtr();
        m_sda = 1'b0;
        qtr();
        m_scl = 1'b0;
        qtr();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        qtr();
        scl_high();
        qtr();
        m_sda = 1'b1;
        qtr();
        qtr();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(mack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d0;
        logic [7:0] d1;
        int         b0;
        int         b1;
        int         b2;

        tx_q[0] = 8'h5A;
        tx_q[1] = 8'h96;
        tx_q[2] = 8'h81;
        tx_q[3] = 8'h00;
        tx_q[4] = 8'h77;
        tx_q[5] = 8'h00;
        tx_q[6] = 8'h00;
        tx_q[7] = 8'h00;
        tx_valid    = 1'b1;
        m_scl       = 1'b1;
        m_sda       = 1'b1;
        i2c_reset_n = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_outputs",
              32'({sda_oe, scl_oe, rx_valid, tx_req, tx_underrun,
                   busy, addressed, rw, rx_data}), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        i2c_reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Write 0x3C, 0xC3 to 0x50.
        b0 = rx_cnt;
        i2c_start();
        check("t1_busy", 32'(busy), 32'd1);
        write_byte(8'hA0, ack);
        check("t1_addr_ack", 32'(ack), 32'(I2C_ACK));
        check("t1_addressed", 32'(addressed), 32'd1);
        check("t1_rw", 32'(rw), 32'd0);
        write_byte(8'h3C, ack);
        check("t1_d0_ack", 32'(ack), 32'(I2C_ACK));
        write_byte(8'hC3, ack);
        check("t1_d1_ack", 32'(ack), 32'(I2C_ACK));
        i2c_stop();
        check("t1_rx_cnt", 32'(rx_cnt - b0), 32'd2);
        check("t1_rx0", 32'(rx_log[b0]), 32'h3C);
        check("t1_rx1", 32'(rx_log[b0+1]), 32'hC3);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_addr_end", 32'(addressed), 32'd0);

        // Read two bytes, ACK then NACK.
        b0 = req_cnt;
        i2c_start();
        write_byte(8'hA1, ack);
        check("t2_addr_ack", 32'(ack), 32'(I2C_ACK));
        check("t2_rw", 32'(rw), 32'd1);
        read_byte(I2C_ACK, d0);
        read_byte(I2C_NACK, d1);
        check("t2_byte0", 32'(d0), 32'h5A);
        check("t2_byte1", 32'(d1), 32'h96);
        check("t2_tx_req", 32'(req_cnt - b0), 32'd2);
        check("t2_wait_stop", 32'(dut.state_q), 32'(WAIT_STOP));
        i2c_stop();
        check("t2_idle", 32'(dut.state_q), 32'(IDLE));
        check("t2_busy_end", 32'(busy), 32'd0);

        // Foreign address 0x51.
        b0 = oe_seen;
        b1 = rx_cnt;
        i2c_start();
        write_byte(8'hA2, ack);
        check("t3_addr_nack", 32'(ack), 32'(I2C_NACK));
        write_byte(8'h3C, ack);
        check("t3_data_nack", 32'(ack), 32'(I2C_NACK));
        check("t3_addressed", 32'(addressed), 32'd0);
        i2c_stop();
        check("t3_sda_oe", 32'(oe_seen - b0), 32'd0);
        check("t3_rx_cnt", 32'(rx_cnt - b1), 32'd0);

        // Write then repeated START into read.
        i2c_start();
        write_byte(8'hA0, ack);
        check("t4_wr_ack", 32'(ack), 32'(I2C_ACK));
        write_byte(8'h3C, ack);
        check("t4_d_ack", 32'(ack), 32'(I2C_ACK));
        check("t4_rw0", 32'(rw), 32'd0);
        check("t4_rx", 32'(rx_log[rx_cnt-1]), 32'h3C);
        i2c_start();
        b2 = oe_rise;
        write_byte(8'hA1, ack);
        check("t4_rd_ack", 32'(ack), 32'(I2C_ACK));
        check("t4_ack_count", 32'(oe_rise - b2), 32'd1);
        check("t4_rw1", 32'(rw), 32'd1);
        check("t4_addressed", 32'(addressed), 32'd1);
        read_byte(I2C_NACK, d0);
        check("t4_byte", 32'(d0), 32'h81);
        i2c_stop();

        // Asynchronous reset while driving a zero bit.
        i2c_start();
        write_byte(8'hA1, ack);
        check("t5_addr_ack", 32'(ack), 32'(I2C_ACK));
        clock_bit(1'b1, s);
        check("t5_bit7", 32'(s), 32'd0);
        check("t5_driving", 32'(sda_oe), 32'd1);
        i2c_reset_n = 1'b0;
        #1;
        check("t5_sda_rel", 32'(sda_oe), 32'd0);
        check("t5_state", 32'(dut.state_q), 32'(IDLE));
        check("t5_busy", 32'(busy), 32'd0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        repeat (3) @(negedge clk);
        i2c_reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_idle", 32'(dut.state_q), 32'(IDLE));

        // Read with no client data ready.
        tx_valid = 1'b0;
        b0 = und_cnt;
        b1 = str_clk;
        i2c_start();
        write_byte(8'hA1, ack);
        check("t6_addr_ack", 32'(ack), 32'(I2C_ACK));
        fork
            read_byte(I2C_NACK, d0);
            begin
                repeat (50) @(negedge clk);
`ifdef I2C_TARGET_STRETCH_EN
                check("t6_stretching", 32'(scl_oe), 32'd1);
`endif
                tx_valid = 1'b1;
            end
        join
`ifdef I2C_TARGET_STRETCH_EN
        check("t6_byte", 32'(d0), 32'h77);
        check("t6_underrun", 32'(und_cnt - b0), 32'd0);
        check("t6_stretch_len", 32'((str_clk - b1) >= 50), 32'd1);
`else
        check("t6_byte", 32'(d0), 32'hFF);
        check("t6_underrun", 32'(und_cnt - b0), 32'd1);
        check("t6_no_stretch", 32'(str_clk - b1), 32'd0);
`endif
        i2c_stop();
        check("t6_busy_end", 32'(busy), 32'd0);
        check("t6_scl_rel", 32'(scl_oe), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
